trace_decoder: RTL and testbench

Reverse direction of the program-path symbol encoder. Accepts the 4-bit opcode stream issued by the DPC control sequencer and converts each opcode back to its Brainfuck ASCII symbol. Output is a byte stream for the front-panel/serial trace port. Opcodes are buffered in a small FIFO; newlines are inserted at a fixed column and after HALT.

---
 rtl/dpc_pkg.sv | 46 ++++
 rtl/opcode_fifo.sv | 53 +++++
 rtl/trace_decoder.sv | 150 +++++++++++++++
 tb/tb_trace_decoder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpc_pkg.sv
// Shared DPC opcode definitions, trace ASCII constants and the opcode-to-symbol lookup.
package dpc_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_INC   = 4'd1;
  localparam logic [3:0] OP_DEC   = 4'd2;
  localparam logic [3:0] OP_RIGHT = 4'd3;
  localparam logic [3:0] OP_LEFT  = 4'd4;
  localparam logic [3:0] OP_JZ    = 4'd5;
  localparam logic [3:0] OP_JNZ   = 4'd6;
  localparam logic [3:0] OP_OUT   = 4'd7;
  localparam logic [3:0] OP_IN    = 4'd8;
  localparam logic [3:0] OP_HALT  = 4'd9;

  localparam logic [7:0] ASCII_NOP   = 8'h5F;
  localparam logic [7:0] ASCII_INC   = 8'h2B;
  localparam logic [7:0] ASCII_DEC   = 8'h2D;
  localparam logic [7:0] ASCII_RIGHT = 8'h3E;
  localparam logic [7:0] ASCII_LEFT  = 8'h3C;
  localparam logic [7:0] ASCII_JZ    = 8'h5B;
  localparam logic [7:0] ASCII_JNZ   = 8'h5D;
  localparam logic [7:0] ASCII_OUT   = 8'h2E;
  localparam logic [7:0] ASCII_IN    = 8'h2C;
  localparam logic [7:0] ASCII_HALT  = 8'h23;
  localparam logic [7:0] ASCII_UNK   = 8'h3F;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  function automatic logic [7:0] opToAscii(input logic [3:0] op);
    case (op)
      OP_NOP:   return ASCII_NOP;
      OP_INC:   return ASCII_INC;
      OP_DEC:   return ASCII_DEC;
      OP_RIGHT: return ASCII_RIGHT;
      OP_LEFT:  return ASCII_LEFT;
      OP_JZ:    return ASCII_JZ;
      OP_JNZ:   return ASCII_JNZ;
      OP_OUT:   return ASCII_OUT;
      OP_IN:    return ASCII_IN;
      OP_HALT:  return ASCII_HALT;
      default:  return ASCII_UNK;
    endcase
  endfunction

endpackage

// File: rtl/opcode_fifo.sv
// Power-of-two opcode FIFO with occupancy count and synchronous flush (clr wins).
module opcode_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     Rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr,
  input  logic [3:0]               din,
  output logic [3:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] wrPtr;
  logic          doPush;
  logic          doPop;

  assign full   = (fill == FW'(DEPTH));
  assign empty  = (fill == '0);
  assign head   = mem[rdPtr];
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      fill  <= '0;
    end else if (clr) begin
      rdPtr <= '0;
      wrPtr <= '0;
      fill  <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      fill <= fill + FW'(doPush) - FW'(doPop);
    end
  end

  // Storage needs no reset; fill/pointers define what is valid.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/trace_decoder.sv
// Opcode-to-ASCII trace decoder with column wrap and HALT line termination.
// Build option: TRACE_NOP_EN makes NOP emit '_' instead of being dropped.
module trace_decoder
  import dpc_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned LINE_LEN = 64
) (
  input  logic                   clk,
  input  logic                   Rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_opcode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   halted
);

  localparam int unsigned FW = $clog2(DEPTH) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYM  = 2'd1;
  localparam logic [1:0] ST_NL   = 2'd2;

  logic [1:0]    state, stateNext;
  logic [7:0]    dataNext;
  logic [7:0]    col, colNext, colInc;
  logic          haltLine, haltLineNext;
  logic          haltedNext;
  logic          advance;
  logic          pushC, popC, clrC;
  logic [3:0]    fifoHead;
  logic          fifoFull, fifoEmpty;
  logic          headDrop, headHalt;
  logic [7:0]    headSym;
  logic [FW-1:0] fillNext;

  assign pushC    = in_valid && in_ready;
  assign colInc   = col + 8'd1;
  assign headSym  = opToAscii(fifoHead);
  assign headHalt = (fifoHead == OP_HALT);
`ifdef TRACE_NOP_EN
  assign headDrop = 1'b0;
`else
  assign headDrop = (fifoHead == OP_NOP);
`endif

  opcode_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk   (clk),
    .Rst   (Rst),
    .push  (pushC),
    .pop   (popC),
    .clr   (clrC),
    .din   (in_opcode),
    .head  (fifoHead),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .fill  (fill)
  );

  // Output sequencing: next state, next byte, column and halt tracking.
  always_comb begin
    stateNext    = state;
    dataNext     = out_data;
    colNext      = col;
    haltLineNext = haltLine;
    haltedNext   = halted;
    popC         = 1'b0;
    clrC         = 1'b0;
    advance      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifoEmpty && !halted) begin
          popC = 1'b1;
          if (!headDrop) begin
            stateNext    = ST_SYM;
            dataNext     = headSym;
            haltLineNext = headHalt;
          end
        end
      end
      ST_SYM: begin
        if (out_ready) begin
          colNext = colInc;
          if (haltLine || (colInc == 8'(LINE_LEN))) begin
            dataNext  = ASCII_LF;
            stateNext = ST_NL;
          end else begin
            advance = 1'b1;
          end
        end
      end
      ST_NL: begin
        if (out_ready) begin
          colNext = '0;
          if (haltLine) begin
            haltedNext   = 1'b1;
            clrC         = 1'b1;
            haltLineNext = 1'b0;
            stateNext    = ST_IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: stateNext = ST_IDLE;
    endcase
    // Shared back-to-back load after a consumed byte.
    if (advance) begin
      if (fifoEmpty) begin
        stateNext = ST_IDLE;
      end else begin
        popC = 1'b1;
        if (headDrop) begin
          stateNext = ST_IDLE;
        end else begin
          stateNext    = ST_SYM;
          dataNext     = headSym;
          haltLineNext = headHalt;
        end
      end
    end
  end

  // in_ready is precomputed from next-cycle occupancy so it never depends on out_ready.
  assign fillNext = clrC ? '0 : (fill + FW'(pushC) - FW'(popC));

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      col       <= 8'd0;
      haltLine  <= 1'b0;
      halted    <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= stateNext;
      out_valid <= (stateNext != ST_IDLE);
      out_data  <= dataNext;
      col       <= colNext;
      haltLine  <= haltLineNext;
      halted    <= haltedNext;
      in_ready  <= !haltedNext && (fillNext != FW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_trace_decoder.sv
// Randomized + directed bench for trace_decoder against a symbol-stream reference model.
module tb_trace_decoder;

  localparam int unsigned DEPTH    = 4;
  localparam int          LINE_LEN = 4;
  localparam int unsigned FW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          Rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_opcode = 4'd0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    out_data;
  logic [FW-1:0] fill;
  logic          halted;

  trace_decoder #(.DEPTH(DEPTH), .LINE_LEN(LINE_LEN)) dut (
    .clk       (clk),
    .Rst       (Rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .fill      (fill),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: expected byte stream derived from accepted opcodes.
  logic [7:0] expQ[$];
  bit         endQ[$];
  int         mCol = 0;
  bit         mHaltSeen = 0;
  bit         mHalted = 0;
  logic [7:0] outLog[$];
  int         outCyc[$];
  int         accCyc[$];
  int         accCount = 0;
  bit         prevStall = 0;
  logic [7:0] prevData = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit dropped(input logic [3:0] op);
`ifdef TRACE_NOP_EN
    return 1'b0;
`else
    return op == 4'd0;
`endif
  endfunction

  function automatic logic [7:0] sym(input logic [3:0] op);
    string s;
    s = "_+-><[].,#";
    if (op < 4'd10) return s[int'(op)];
    return 8'h3F;
  endfunction

  function automatic void modelAccept(input logic [3:0] op);
    if (mHaltSeen || dropped(op)) return;
    expQ.push_back(sym(op));
    endQ.push_back(1'b0);
    mCol++;
    if (op == 4'd9) begin
      expQ.push_back(8'h0A);
      endQ.push_back(1'b1);
      mHaltSeen = 1'b1;
      mCol = 0;
    end else if (mCol == LINE_LEN) begin
      expQ.push_back(8'h0A);
      endQ.push_back(1'b0);
      mCol = 0;
    end
  endfunction

  // Compare process: inputs/outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!Rst) begin
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  32'(out_data),  32'h00);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_fill",      32'(fill),      32'd0);
      check("rst_halted",    32'(halted),    32'd0);
      expQ.delete();
      endQ.delete();
      mCol = 0;
      mHaltSeen = 1'b0;
      mHalted = 1'b0;
      prevStall = 1'b0;
    end else begin
      check("halted", 32'(halted), 32'(mHalted));
      check("in_ready", 32'(in_ready), 32'(!mHalted && (32'(fill) != DEPTH)));
      check("fill_range", 32'(32'(fill) <= DEPTH), 32'd1);
      if (mHalted) check("fill_after_halt", 32'(fill), 32'd0);
      if (prevStall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prevData));
      end
      if (out_valid && out_ready) begin
        outLog.push_back(out_data);
        outCyc.push_back(cyc);
        if (expQ.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte: got %0h expected none (cycle %0d)", out_data, cyc);
        end else begin
          check("out_data", 32'(out_data), 32'(expQ[0]));
          if (endQ[0]) mHalted = 1'b1;
          void'(expQ.pop_front());
          void'(endQ.pop_front());
        end
      end
      prevStall = out_valid && !out_ready;
      prevData  = out_data;
      if (in_valid && in_ready) begin
        accCyc.push_back(cyc);
        accCount++;
        modelAccept(in_opcode);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    in_valid = 1'b0;
    Rst = 1'b0;
    repeat (2) tick();
    Rst = 1'b1;
    tick();
  endtask

  task automatic pushOp(input logic [3:0] op);
    int n;
    n = 0;
    in_opcode = op;
    in_valid  = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        tests++;
        fails++;
        $display("FAIL push_timeout: got no accept expected accept of op %0d", op);
        break;
      end
      @(posedge clk);
      #1;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (expQ.size() == 0 && !out_valid && fill == '0) break;
      n++;
      if (n > 300) begin
        tests++;
        fails++;
        $display("FAIL drain_timeout: got %0d bytes pending expected 0", expQ.size());
        break;
      end
    end
    tick();
  endtask

  task automatic checkSeq(input string name, input int start, input logic [7:0] e[$]);
    check({name, "_len"}, 32'(outLog.size() - start), 32'(e.size()));
    for (int i = 0; i < e.size(); i++) begin
      if (start + i < outLog.size()) check(name, 32'(outLog[start + i]), 32'(e[i]));
    end
  endtask

  initial begin
    int s;
    int a;
    logic [7:0] e[$];
    logic [3:0] op;

    repeat (3) tick();
    Rst = 1'b1;
    tick();

    // Four symbols back-to-back; first byte one edge after the accepting edge.
    out_ready = 1'b1;
    s = outLog.size();
    a = accCyc.size();
    pushOp(4'd1); pushOp(4'd1); pushOp(4'd3); pushOp(4'd5);
    drain();
    e = '{8'h2B, 8'h2B, 8'h3E, 8'h5B, 8'h0A};
    checkSeq("burst", s, e);
    if (outCyc.size() > s + 3 && accCyc.size() > a) begin
      check("burst_latency", 32'(outCyc[s] - accCyc[a]), 32'd2);
      check("burst_consecutive", 32'(outCyc[s + 3] - outCyc[s]), 32'd3);
    end

    // Line wrap every LINE_LEN symbols.
    doReset();
    s = outLog.size();
    repeat (8) pushOp(4'd1);
    drain();
    e = '{8'h2B, 8'h2B, 8'h2B, 8'h2B, 8'h0A, 8'h2B, 8'h2B, 8'h2B, 8'h2B, 8'h0A};
    checkSeq("wrap", s, e);

    // Backpressure: output register plus DEPTH entries.
    doReset();
    out_ready = 1'b0;
    s = outLog.size();
    a = accCount;
    in_opcode = 4'd2;
    in_valid = 1'b1;
    repeat (8) tick();
    in_valid = 1'b0;
    check("bp_accepted", 32'(accCount - a), 32'd5);
    @(negedge clk);
    check("bp_fill", 32'(fill), 32'd4);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_out_data", 32'(out_data), 32'h2D);
    tick();
    drain();
    e = '{8'h2D, 8'h2D, 8'h2D, 8'h2D, 8'h0A, 8'h2D};
    checkSeq("bp", s, e);

    // Reset while a byte is pending: nothing may be emitted.
    doReset();
    out_ready = 1'b0;
    pushOp(4'd7);
    tick();
    @(negedge clk);
    check("mid_valid", 32'(out_valid), 32'd1);
    check("mid_data", 32'(out_data), 32'h2E);
    tick();
    s = outLog.size();
    doReset();
    out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("mid_after_valid", 32'(out_valid), 32'd0);
    check("mid_after_data", 32'(out_data), 32'h00);
    check("mid_no_byte", 32'(outLog.size() - s), 32'd0);
    tick();

    // HALT closes the stream.
    doReset();
    out_ready = 1'b1;
    s = outLog.size();
    pushOp(4'd9);
    pushOp(4'd1);
    drain();
    e = '{8'h23, 8'h0A};
    checkSeq("halt", s, e);
    @(negedge clk);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_in_ready", 32'(in_ready), 32'd0);
    check("halt_fill", 32'(fill), 32'd0);
    tick();
    doReset();
    @(negedge clk);
    check("halt_cleared", 32'(halted), 32'd0);
    check("halt_ready_back", 32'(in_ready), 32'd1);
    tick();

    // NOP handling and column after a dropped opcode.
    doReset();
    out_ready = 1'b1;
    s = outLog.size();
    pushOp(4'd0); pushOp(4'd12); pushOp(4'd6); pushOp(4'd1); pushOp(4'd1);
    drain();
`ifdef TRACE_NOP_EN
    e = '{8'h5F, 8'h3F, 8'h5D, 8'h2B, 8'h0A, 8'h2B};
`else
    e = '{8'h3F, 8'h5D, 8'h2B, 8'h2B, 8'h0A};
`endif
    checkSeq("nop", s, e);

    // Random traffic with random backpressure; HALT only in later rounds.
    for (int r = 0; r < 4; r++) begin
      doReset();
      for (int c = 0; c < 1500; c++) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'd9 && (r == 0 || $urandom_range(0, 9) != 0)) op = 4'd1;
        in_opcode = op;
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      in_valid = 1'b0;
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
